// File: rtl/tff_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tff_sched_pkg
// Brief    : Shared state constants and round-robin search for the scheduler.
// Revision : 1.0
// ============================================================================
package tff_sched_pkg;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    localparam int c_NREQ_DEFAULT = 4;
    localparam int c_OWNW         = $clog2(c_NREQ_DEFAULT);
    localparam int c_MAX_REQ      = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // First valid requester in the order ptr+1, ptr+2, ... wrapping at nreq.
    function automatic rr_pick_t rr_search(
        input logic [c_MAX_REQ-1:0] valid,
        input int                   nreq,
        input int                   ptr
    );
        rr_pick_t r;
        int       cand;
        r = '0;
        for (int k = 1; k <= c_MAX_REQ; k++) begin
            if (k <= nreq) begin
                cand = ptr + k;
                if (cand >= nreq) cand = cand - nreq;
                if (!r.found && valid[cand[4:0]]) begin
                    r.found = 1'b1;
                    r.idx   = cand[4:0];
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tff_toggle_scheduler_bank.sv
`default_nettype none
// ============================================================================
// Module   : tff_bank
// Brief    : Bank of T flip-flops with synchronous reset and clear.
// Revision : 1.0
// ============================================================================
module tff_bank
    import tff_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic r_bit;
        always_ff @(posedge clk) begin
            if (rst || clr) begin
                r_bit <= 1'b0;
            end else if (t[i]) begin
                r_bit <= ~r_bit;
            end
        end
        assign q[i] = r_bit;
    end

endmodule
`default_nettype wire

// File: rtl/tff_toggle_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tff_toggle_scheduler
// Brief    : Round-robin arbitration of toggle requests onto a shared T-flop bank.
// Revision : 1.0
// ============================================================================
module tff_toggle_scheduler
    import tff_sched_pkg::*;
#(
    parameter int NREQ  = c_NREQ_DEFAULT,
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_mask,
    input  logic [NREQ*CNTW-1:0]    req_count,
    input  logic                    clr,
    output logic [WIDTH-1:0]        q,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    done
);

    localparam int c_OWN_W = $clog2(NREQ);

    logic [0:0]         r_state;
    logic [CNTW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_mask;
    logic [c_OWN_W-1:0] r_ptr;
    logic [c_OWN_W-1:0] r_owner;
    logic               r_done;

    rr_pick_t           w_pick;
    logic [c_OWN_W-1:0] w_grant;
    logic [NREQ-1:0]    w_ready;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_sel_mask;
    logic [CNTW-1:0]    w_sel_count;
    logic [WIDTH-1:0]   w_t;

    always_comb begin
        w_pick      = rr_search(c_MAX_REQ'(req_valid), NREQ, int'(r_ptr));
        w_grant     = w_pick.idx[c_OWN_W-1:0];
        w_ready     = '0;
        // Ready is held low through reset so nothing is accepted from an unknown state.
        if (!rst && (r_state == c_ST_IDLE) && w_pick.found) begin
            w_ready[w_grant] = 1'b1;
        end
        w_xfer      = |(req_valid & w_ready);
        w_sel_mask  = req_mask[int'(w_grant)*WIDTH +: WIDTH];
        w_sel_count = req_count[int'(w_grant)*CNTW +: CNTW];
        w_t         = (r_state == c_ST_RUN) ? r_mask : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_ptr   <= c_OWN_W'(NREQ - 1);
            r_owner <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_xfer) begin
                        r_mask  <= w_sel_mask;
                        r_owner <= w_grant;
                        r_ptr   <= w_grant;
                        // A zero-length request completes immediately without touching the bank.
                        if (w_sel_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cnt   <= w_sel_count;
                            r_state <= c_ST_RUN;
                        end
                    end
                end
                c_ST_RUN: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNTW'(1);
                    if (r_cnt <= CNTW'(1)) begin
                        r_state <= c_ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    tff_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .t   (w_t),
        .q   (q)
    );

    assign req_ready = w_ready;
    assign busy      = (r_state == c_ST_RUN);
    assign owner     = r_owner;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tff_toggle_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tff_toggle_scheduler
// Brief    : Directed table, hand sequences and random run against a reference model.
// Revision : 1.0
// ============================================================================
module tb_tff_toggle_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CNTW  = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  clr = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_mask = '0;
    logic [NREQ*CNTW-1:0]  req_count = '0;
    logic [WIDTH-1:0]      q;
    logic                  busy;
    logic [1:0]            owner;
    logic                  done;

    always #5 clk = ~clk;

    tff_toggle_scheduler #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mask  (req_mask),
        .req_count (req_count),
        .clr       (clr),
        .q         (q),
        .busy      (busy),
        .owner     (owner),
        .done      (done)
    );

    typedef struct {
        logic        rst;
        logic        clr;
        logic [3:0]  valid;
        logic [31:0] mask;
        logic [15:0] count;
        logic [3:0]  e_ready;
        logic [7:0]  e_q;
        logic        e_busy;
        logic        e_done;
        logic [1:0]  e_owner;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: remaining toggle count per grant, integer round-robin pointer.
    int         m_rem   = 0;
    int         m_ptr   = NREQ - 1;
    int         m_owner = 0;
    logic [7:0] m_q     = '0;
    logic [7:0] m_mask  = '0;
    logic       m_done  = 1'b0;

    function automatic int m_winner(input logic [3:0] v, input logic r);
        if (r || m_rem > 0) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        w = m_winner(req_valid, rst);
        if (rst) begin
            m_q = '0; m_rem = 0; m_ptr = NREQ - 1; m_owner = 0; m_done = 1'b0; m_mask = '0;
        end else begin
            if (m_rem > 0) m_q = m_q ^ m_mask;
            if (clr) m_q = '0;
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_done = 1'b1;
            end else if (w >= 0) begin
                m_ptr   = w;
                m_owner = w;
                m_mask  = req_mask[w*WIDTH +: WIDTH];
                m_rem   = int'(req_count[w*CNTW +: CNTW]);
                if (m_rem == 0) m_done = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample ready before the edge, outputs 1ns after.
    task automatic cycle(input logic r, input logic c, input logic [3:0] v,
                         input logic [31:0] m, input logic [15:0] cn,
                         output logic [3:0] rdy, output logic [3:0] mrdy);
        int w;
        @(negedge clk);
        rst = r; clr = c; req_valid = v; req_mask = m; req_count = cn;
        #1;
        rdy  = req_ready;
        w    = m_winner(v, r);
        mrdy = (w >= 0) ? 4'(1 << w) : 4'h0;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic add(input logic r, input logic c, input logic [3:0] v, input logic [31:0] m,
                       input logic [15:0] cn, input logic [3:0] er, input logic [7:0] eq,
                       input logic eb, input logic ed, input logic [1:0] eo);
        vec_t x;
        x = '{r, c, v, m, cn, er, eq, eb, ed, eo};
        tbl.push_back(x);
    endtask

    initial begin
        logic [3:0] rdy, mrdy;
        logic [7:0] exp_q;
        int         grants[5];
        logic [31:0] rm;
        logic [15:0] rc;

        //   rst clr valid mask           count     ready q      busy done owner
        add(1, 0, 4'hF, 32'h0,         16'h0,    4'h0, 8'h00, 0, 0, 2'd0);
        add(1, 0, 4'hF, 32'h0,         16'h0,    4'h0, 8'h00, 0, 0, 2'd0);
        add(0, 0, 4'h1, 32'h00000005,  16'h0003, 4'h1, 8'h00, 1, 0, 2'd0);
        add(0, 0, 4'h0, 32'h00000005,  16'h0003, 4'h0, 8'h05, 1, 0, 2'd0);
        add(0, 0, 4'h0, 32'h00000005,  16'h0003, 4'h0, 8'h00, 1, 0, 2'd0);
        add(0, 0, 4'h0, 32'h00000005,  16'h0003, 4'h0, 8'h05, 0, 1, 2'd0);
        add(0, 0, 4'h0, 32'h00000005,  16'h0003, 4'h0, 8'h05, 0, 0, 2'd0);
        add(0, 0, 4'h8, 32'hFF000000,  16'h0000, 4'h8, 8'h05, 0, 1, 2'd3);
        add(0, 0, 4'h0, 32'hFF000000,  16'h0000, 4'h0, 8'h05, 0, 0, 2'd3);
        add(0, 1, 4'h0, 32'h0,         16'h0,    4'h0, 8'h00, 0, 0, 2'd3);
        add(0, 0, 4'h2, 32'h0000FF00,  16'h0040, 4'h2, 8'h00, 1, 0, 2'd1);
        add(0, 0, 4'h0, 32'h0000FF00,  16'h0040, 4'h0, 8'hFF, 1, 0, 2'd1);
        add(0, 1, 4'h0, 32'h0000FF00,  16'h0040, 4'h0, 8'h00, 1, 0, 2'd1);
        add(0, 0, 4'h0, 32'h0000FF00,  16'h0040, 4'h0, 8'hFF, 1, 0, 2'd1);
        add(0, 0, 4'h0, 32'h0000FF00,  16'h0040, 4'h0, 8'h00, 0, 1, 2'd1);
        add(0, 0, 4'h0, 32'h0000FF00,  16'h0040, 4'h0, 8'h00, 0, 0, 2'd1);
        add(0, 0, 4'h4, 32'h000F0000,  16'h0500, 4'h4, 8'h00, 1, 0, 2'd2);
        add(0, 0, 4'h0, 32'h000F0000,  16'h0500, 4'h0, 8'h0F, 1, 0, 2'd2);
        add(1, 0, 4'h0, 32'h000F0000,  16'h0500, 4'h0, 8'h00, 0, 0, 2'd0);
        add(0, 0, 4'h0, 32'h0,         16'h0,    4'h0, 8'h00, 0, 0, 2'd0);

        foreach (tbl[i]) begin
            cycle(tbl[i].rst, tbl[i].clr, tbl[i].valid, tbl[i].mask, tbl[i].count, rdy, mrdy);
            chk($sformatf("row%0d ready", i), 32'(rdy),   32'(tbl[i].e_ready));
            chk($sformatf("row%0d q", i),     32'(q),     32'(tbl[i].e_q));
            chk($sformatf("row%0d busy", i),  32'(busy),  32'(tbl[i].e_busy));
            chk($sformatf("row%0d done", i),  32'(done),  32'(tbl[i].e_done));
            chk($sformatf("row%0d owner", i), 32'(owner), 32'(tbl[i].e_owner));
        end

        // Three requesters held valid with count=1: grants rotate 0,1,2,0,1.
        grants = '{0, 1, 2, 0, 1};
        exp_q  = 8'h00;
        for (int g = 0; g < 5; g++) begin
            cycle(0, 0, 4'h7, 32'h00040201, 16'h0111, rdy, mrdy);
            chk($sformatf("rr%0d ready", g), 32'(rdy),   32'(1 << grants[g]));
            chk($sformatf("rr%0d owner", g), 32'(owner), 32'(grants[g]));
            chk($sformatf("rr%0d busy", g),  32'(busy),  32'd1);
            exp_q = exp_q ^ 8'(1 << grants[g]);
            cycle(0, 0, 4'h7, 32'h00040201, 16'h0111, rdy, mrdy);
            chk($sformatf("rr%0d run ready", g), 32'(rdy),  32'd0);
            chk($sformatf("rr%0d q", g),         32'(q),    32'(exp_q));
            chk($sformatf("rr%0d done", g),      32'(done), 32'd1);
            chk($sformatf("rr%0d idle", g),      32'(busy), 32'd0);
        end

        for (int n = 0; n < 400; n++) begin
            rm = $urandom;
            for (int k = 0; k < NREQ; k++) begin
                rc[k*CNTW +: CNTW] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 5));
            end
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                  4'($urandom), rm, rc, rdy, mrdy);
            chk($sformatf("rnd%0d ready", n), 32'(rdy),   32'(mrdy));
            chk($sformatf("rnd%0d q", n),     32'(q),     32'(m_q));
            chk($sformatf("rnd%0d busy", n),  32'(busy),  32'(m_rem > 0));
            chk($sformatf("rnd%0d done", n),  32'(done),  32'(m_done));
            chk($sformatf("rnd%0d owner", n), 32'(owner), 32'(m_owner));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
